// File: rtl/glb_gin_sender.sv
// GLB-side GIN transmitter: streams a programmed SRAM block out through a
// 2-entry FIFO onto a valid/ready port, tagging each word with its (X,Y) destination.
module glb_gin_sender #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 16,
    parameter int XID_BITS  = 5,
    parameter int YID_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] cfg_base_addr,
    input  logic [15:0]          cfg_words_per_tag,
    input  logic [XID_BITS-1:0]  cfg_num_x,
    input  logic [YID_BITS-1:0]  cfg_num_y,
    output logic                 busy,
    output logic                 done,
    output logic                 sram_re,
    output logic [ADDR_BITS-1:0] sram_addr,
    input  logic [DATA_BITS-1:0] sram_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic [XID_BITS-1:0]  tag_X,
    output logic [YID_BITS-1:0]  tag_Y
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam logic [XID_BITS-1:0] X_ONE = XID_BITS'(1);
    localparam logic [YID_BITS-1:0] Y_ONE = YID_BITS'(1);

    state_t                state, state_next;
    logic [15:0]           wpt_q, wcnt;
    logic [XID_BITS-1:0]   nx_q, xcnt;
    logic [YID_BITS-1:0]   ny_q, ycnt;
    logic [ADDR_BITS-1:0]  addr_q;
    logic                  inflight;
    logic [XID_BITS-1:0]   inflight_x;
    logic [YID_BITS-1:0]   inflight_y;
    logic [DATA_BITS-1:0]  fifo_data [2];
    logic [XID_BITS-1:0]   fifo_x [2];
    logic [YID_BITS-1:0]   fifo_y [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            fifo_count, fifo_count_next, occ;
    logic                  push, pop, issue, last_issue, accept, zero_start, drain_done;
    logic                  wcnt_last, xcnt_last, ycnt_last;

    assign sram_addr = addr_q;
    assign sram_re   = issue;
    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_data[rd_ptr];
    assign tag_X     = fifo_x[rd_ptr];
    assign tag_Y     = fifo_y[rd_ptr];

    always_comb begin
        push       = inflight;
        pop        = out_valid && out_ready;
        accept     = 1'b0;
        zero_start = 1'b0;
        if (state == IDLE && start) begin
            if (cfg_words_per_tag != '0 && cfg_num_x != '0 && cfg_num_y != '0)
                accept = 1'b1;
            else
                zero_start = 1'b1;
        end
        // FIFO slots plus the read still in the SRAM pipe bound what may be issued
        occ        = fifo_count + {1'b0, inflight};
        issue      = (state == ISSUE) && ((occ < 2'd2) || (occ == 2'd2 && pop));
        wcnt_last  = (wcnt == wpt_q - 16'd1);
        xcnt_last  = (xcnt == nx_q - X_ONE);
        ycnt_last  = (ycnt == ny_q - Y_ONE);
        last_issue = issue && wcnt_last && xcnt_last && ycnt_last;
        unique case ({push, pop})
            2'b10:   fifo_count_next = fifo_count + 2'd1;
            2'b01:   fifo_count_next = fifo_count - 2'd1;
            default: fifo_count_next = fifo_count;
        endcase
        drain_done = (state == DRAIN) && !inflight && (fifo_count_next == 2'd0);
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   if (last_issue) state_next = DRAIN;
            DRAIN:   if (drain_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            addr_q     <= '0;
            wpt_q      <= '0;
            nx_q       <= '0;
            ny_q       <= '0;
            wcnt       <= '0;
            xcnt       <= '0;
            ycnt       <= '0;
            inflight   <= 1'b0;
            inflight_x <= '0;
            inflight_y <= '0;
        end else begin
            done     <= zero_start || drain_done;
            inflight <= issue;
            if (accept)          busy <= 1'b1;
            else if (drain_done) busy <= 1'b0;
            if (accept) begin
                addr_q <= cfg_base_addr;
                wpt_q  <= cfg_words_per_tag;
                nx_q   <= cfg_num_x;
                ny_q   <= cfg_num_y;
                wcnt   <= '0;
                xcnt   <= '0;
                ycnt   <= '0;
            end else if (issue) begin
                addr_q     <= addr_q + ADDR_BITS'(1);
                inflight_x <= xcnt;
                inflight_y <= ycnt;
                if (!wcnt_last) begin
                    wcnt <= wcnt + 16'd1;
                end else begin
                    wcnt <= '0;
                    if (!xcnt_last) begin
                        xcnt <= xcnt + X_ONE;
                    end else begin
                        xcnt <= '0;
                        ycnt <= ycnt + Y_ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_x[i]    <= '0;
                fifo_y[i]    <= '0;
            end
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= sram_rdata;
                fifo_x[wr_ptr]    <= inflight_x;
                fifo_y[wr_ptr]    <= inflight_y;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count_next;
        end
    end

endmodule

// File: tb/tb_glb_gin_sender.sv
// Directed bench for glb_gin_sender: SRAM model returns the address as data,
// a negedge monitor scoreboards addresses, words, tags and stall stability.
module tb_glb_gin_sender;

    localparam int DATA_BITS = 32;
    localparam int ADDR_BITS = 16;
    localparam int XID_BITS  = 5;
    localparam int YID_BITS  = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [ADDR_BITS-1:0] cfg_base_addr;
    logic [15:0]          cfg_words_per_tag;
    logic [XID_BITS-1:0]  cfg_num_x;
    logic [YID_BITS-1:0]  cfg_num_y;
    logic                 busy, done, sram_re, out_valid, out_ready;
    logic [ADDR_BITS-1:0] sram_addr;
    logic [DATA_BITS-1:0] sram_rdata = '0;
    logic [DATA_BITS-1:0] out_data;
    logic [XID_BITS-1:0]  tag_X;
    logic [YID_BITS-1:0]  tag_Y;

    glb_gin_sender #(
        .DATA_BITS(DATA_BITS),
        .ADDR_BITS(ADDR_BITS),
        .XID_BITS (XID_BITS),
        .YID_BITS (YID_BITS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .cfg_base_addr    (cfg_base_addr),
        .cfg_words_per_tag(cfg_words_per_tag),
        .cfg_num_x        (cfg_num_x),
        .cfg_num_y        (cfg_num_y),
        .busy             (busy),
        .done             (done),
        .sram_re          (sram_re),
        .sram_addr        (sram_addr),
        .sram_rdata       (sram_rdata),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .tag_X            (tag_X),
        .tag_Y            (tag_Y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (sram_re) sram_rdata <= 32'(sram_addr);

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    logic [15:0]          exp_addr_q[$];
    logic [DATA_BITS-1:0] exp_data_q[$];
    logic [XID_BITS-1:0]  exp_x_q[$];
    logic [YID_BITS-1:0]  exp_y_q[$];
    bit                   mon_en = 1'b0;
    int                   reads_issued, words_seen, done_count, exp_n;
    bit                   stall_prev = 1'b0;
    logic [DATA_BITS-1:0] prev_data;
    logic [XID_BITS-1:0]  prev_x;
    logic [YID_BITS-1:0]  prev_y;

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (sram_re) begin
                reads_issued++;
                if (exp_addr_q.size() == 0) check("read_count", 64'(reads_issued), 64'(exp_n));
                else check("sram_addr", 64'(sram_addr), 64'(exp_addr_q.pop_front()));
            end
            if (stall_prev) begin
                check("stall_valid", 64'(out_valid), 64'(1));
                check("stall_data", 64'(out_data), 64'(prev_data));
                check("stall_tag_X", 64'(tag_X), 64'(prev_x));
                check("stall_tag_Y", 64'(tag_Y), 64'(prev_y));
            end
            if (out_valid && out_ready) begin
                words_seen++;
                if (exp_data_q.size() == 0) check("word_count", 64'(words_seen), 64'(exp_n));
                else begin
                    check("out_data", 64'(out_data), 64'(exp_data_q.pop_front()));
                    check("tag_X", 64'(tag_X), 64'(exp_x_q.pop_front()));
                    check("tag_Y", 64'(tag_Y), 64'(exp_y_q.pop_front()));
                end
            end
            check("occupancy_le2", 64'((reads_issued - words_seen) <= 2), 64'(1));
            if (done) done_count++;
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_x     = tag_X;
            prev_y     = tag_Y;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic build_expect(input logic [15:0] base, input logic [15:0] wpt,
                                input logic [4:0] nx, input logic [3:0] ny);
        int k;
        logic [15:0] a;
        exp_addr_q.delete(); exp_data_q.delete(); exp_x_q.delete(); exp_y_q.delete();
        k = 0;
        for (int y = 0; y < int'(ny); y++)
            for (int x = 0; x < int'(nx); x++)
                for (int w = 0; w < int'(wpt); w++) begin
                    a = base + 16'(k);
                    exp_addr_q.push_back(a);
                    exp_data_q.push_back(32'(a));
                    exp_x_q.push_back(5'(x));
                    exp_y_q.push_back(4'(y));
                    k++;
                end
        exp_n        = k;
        reads_issued = 0;
        words_seen   = 0;
        done_count   = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_sram_re"}, 64'(sram_re), 64'(0));
        check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_sram_addr"}, 64'(sram_addr), 64'(0));
        check({tag, "_out_data"}, 64'(out_data), 64'(0));
        check({tag, "_tag_X"}, 64'(tag_X), 64'(0));
        check({tag, "_tag_Y"}, 64'(tag_Y), 64'(0));
    endtask

    // mode 0: ready held high, cycle-exact checks; mode 1: random ready
    task automatic run_xfer(input logic [15:0] base, input logic [15:0] wpt, input logic [4:0] nx,
                            input logic [3:0] ny, input int mode, input int second_start);
        int cyc;
        bit got_done;
        int n;
        build_expect(base, wpt, nx, ny);
        n = exp_n;
        @(posedge clk); #1;
        cfg_base_addr     = base;
        cfg_words_per_tag = wpt;
        cfg_num_x         = nx;
        cfg_num_y         = ny;
        start             = 1'b1;
        out_ready         = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        mon_en            = 1'b1;
        @(negedge clk);
        cyc      = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == second_start);
            if (cyc == second_start) begin
                cfg_words_per_tag = 16'd9;
                cfg_num_x         = 5'd7;
            end
            out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (mode == 0) begin
                check("busy", 64'(busy), 64'(n > 0 && cyc >= 1 && cyc <= n + 2));
                check("sram_re", 64'(sram_re), 64'(cyc >= 1 && cyc <= n));
                check("out_valid", 64'(out_valid), 64'(n > 0 && cyc >= 3 && cyc <= n + 2));
            end
            if (done) got_done = 1'b1;
        end
        check("done_seen", 64'(got_done), 64'(1));
        if (mode == 0) check("done_cycle", 64'(cyc), 64'((n == 0) ? 1 : n + 3));
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk);
        mon_en = 1'b0;
        check("done_count", 64'(done_count), 64'(1));
        check("reads_total", 64'(reads_issued), 64'(n));
        check("words_total", 64'(words_seen), 64'(n));
        check("exp_left", 64'(exp_data_q.size()), 64'(0));
    endtask

    initial begin
        rst               = 1'b1;
        start             = 1'b0;
        cfg_base_addr     = '0;
        cfg_words_per_tag = '0;
        cfg_num_x         = '0;
        cfg_num_y         = '0;
        out_ready         = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        run_xfer(16'h0010, 16'd4, 5'd1, 4'd1, 0, 0);
        run_xfer(16'h0040, 16'd2, 5'd3, 4'd2, 0, 0);
        run_xfer(16'h0080, 16'd8, 5'd2, 4'd1, 1, 0);
        run_xfer(16'hFFFE, 16'd4, 5'd1, 4'd1, 0, 0);
        run_xfer(16'h0100, 16'd4, 5'd0, 4'd2, 0, 0);
        run_xfer(16'h0110, 16'd0, 5'd2, 4'd2, 0, 0);
        run_xfer(16'h0200, 16'd4, 5'd2, 4'd1, 0, 3);
        run_xfer(16'h0400, 16'd1, 5'd31, 4'd1, 0, 0);
        run_xfer(16'h0500, 16'd2, 5'd2, 4'd3, 1, 0);

        // abort after three words, then a fresh transfer from the same base
        build_expect(16'h0300, 16'd8, 5'd1, 4'd1);
        @(posedge clk); #1;
        cfg_base_addr     = 16'h0300;
        cfg_words_per_tag = 16'd8;
        cfg_num_x         = 5'd1;
        cfg_num_y         = 4'd1;
        start             = 1'b1;
        out_ready         = 1'b1;
        mon_en            = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 50 && words_seen < 3; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
        end
        mon_en = 1'b0;
        check("rst_pre_words", 64'(words_seen), 64'(3));
        #1 rst = 1'b1;
        #1 check_reset_outputs("abort");
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", 64'(done), 64'(0));
            check("abort_busy", 64'(busy), 64'(0));
        end
        rst = 1'b0;
        run_xfer(16'h0300, 16'd8, 5'd1, 4'd1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
